// File: rtl/fetcher_pkg.sv
// rtl/fetcher_pkg.sv - shared constants, FSM states and immediate decoders for the fetcher
package fetcher_pkg;

    localparam int DATA_WIDTH = 32;
    localparam logic [DATA_WIDTH-1:0] ZERO_DATA = '0;

    localparam int ICACHE_ENTRIES = 128;
    localparam int IC_IDX_W       = $clog2(ICACHE_ENTRIES);
    localparam int IC_TAG_W       = 32 - IC_IDX_W - 2;

    localparam int BHT_ENTRIES = 64;
    localparam int BHT_IDX_W   = $clog2(BHT_ENTRIES);

    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_B_TYPE = 7'b1100011;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_MISS = 1'b1
    } fetch_state_t;

    function automatic logic [31:0] j_imm(input logic [31:0] i);
        return {{11{i[31]}}, i[31], i[19:12], i[20], i[30:21], 1'b0};
    endfunction

    function automatic logic [31:0] b_imm(input logic [31:0] i);
        return {{19{i[31]}}, i[31], i[7], i[30:25], i[11:8], 1'b0};
    endfunction

endpackage

// File: rtl/fetcher_icache.sv
// rtl/fetcher_icache.sv - direct-mapped instruction cache: combinational lookup, synchronous fill
module fetcher_icache
    import fetcher_pkg::*;
(
    input  logic                  clk,
    input  logic                  rst,
    input  logic [31:2]           lookup_word,
    output logic                  hit,
    output logic [DATA_WIDTH-1:0] rdata,
    input  logic                  fill_en,
    input  logic [31:2]           fill_word,
    input  logic [DATA_WIDTH-1:0] fill_data
);

    logic [ICACHE_ENTRIES-1:0] valid_q;
    logic [IC_TAG_W-1:0]       tag_q  [ICACHE_ENTRIES];
    logic [DATA_WIDTH-1:0]     data_q [ICACHE_ENTRIES];

    logic [IC_IDX_W-1:0] lookup_idx;
    logic [IC_IDX_W-1:0] fill_idx;

    assign lookup_idx = lookup_word[IC_IDX_W+1:2];
    assign fill_idx   = fill_word[IC_IDX_W+1:2];

    // Only the valid bits need clearing; tag/data are qualified by them.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            valid_q <= '0;
        end else if (fill_en) begin
            valid_q[fill_idx] <= 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (fill_en) begin
            tag_q[fill_idx]  <= fill_word[31:IC_IDX_W+2];
            data_q[fill_idx] <= fill_data;
        end
    end

    assign hit   = valid_q[lookup_idx] && (tag_q[lookup_idx] == lookup_word[31:IC_IDX_W+2]);
    assign rdata = data_q[lookup_idx];

endmodule

// File: rtl/fetcher.sv
// rtl/fetcher.sv - PC owner and instruction issue front end; FETCHER_BHT_EN enables JAL/B-type prediction
module fetcher
    import fetcher_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        rdy,
    input  logic        in_queue_full,
    input  logic        in_rob_flush,
    input  logic [31:0] in_rob_target_pc,
    input  logic        in_rob_br_valid,
    input  logic [31:0] in_rob_br_pc,
    input  logic        in_rob_br_taken,
    output logic        out_mem_req,
    output logic [31:0] out_mem_addr,
    input  logic        in_mem_valid,
    input  logic [31:0] in_mem_data,
    output logic        out_decode_valid,
    output logic [31:0] out_decode_instr,
    output logic [31:0] out_decode_pc,
    output logic        out_decode_jump_ce
);

    fetch_state_t state, state_n;
    logic [31:0]  pc, pc_n;
    logic         req_n, valid_n, jce_n;
    logic [31:0]  addr_n, instr_n, dpc_n;

    logic                  hit;
    logic [DATA_WIDTH-1:0] rdata;
    logic                  fill_en;
    logic                  pred_taken;
    logic [31:0]           next_pc;

    assign fill_en = rdy && (state == ST_MISS) && in_mem_valid;

    fetcher_icache u_icache (
        .clk         (clk),
        .rst         (rst),
        .lookup_word (pc[31:2]),
        .hit         (hit),
        .rdata       (rdata),
        .fill_en     (fill_en),
        .fill_word   (out_mem_addr[31:2]),
        .fill_data   (in_mem_data)
    );

`ifdef FETCHER_BHT_EN
    logic [1:0]           bht_q [BHT_ENTRIES];
    logic [BHT_IDX_W-1:0] br_idx;
    logic [1:0]           cur_ctr;
    logic                 unused_br;

    assign br_idx    = in_rob_br_pc[BHT_IDX_W+1:2];
    assign cur_ctr   = bht_q[pc[BHT_IDX_W+1:2]];
    assign unused_br = ^{in_rob_br_pc[31:BHT_IDX_W+2], in_rob_br_pc[1:0]};

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < BHT_ENTRIES; i++) bht_q[i] <= 2'b01;
        end else if (rdy && in_rob_br_valid) begin
            if (in_rob_br_taken && bht_q[br_idx] != 2'b11)
                bht_q[br_idx] <= bht_q[br_idx] + 2'b01;
            else if (!in_rob_br_taken && bht_q[br_idx] != 2'b00)
                bht_q[br_idx] <= bht_q[br_idx] - 2'b01;
        end
    end

    always_comb begin
        pred_taken = 1'b0;
        next_pc    = pc + 32'd4;
        if (rdata[6:0] == OPC_JAL) begin
            pred_taken = 1'b1;
            next_pc    = pc + j_imm(rdata);
        end else if (rdata[6:0] == OPC_B_TYPE && cur_ctr[1]) begin
            pred_taken = 1'b1;
            next_pc    = pc + b_imm(rdata);
        end
    end
`else
    logic unused_br;
    assign unused_br  = ^{in_rob_br_valid, in_rob_br_pc, in_rob_br_taken};
    assign pred_taken = 1'b0;
    assign next_pc    = pc + 32'd4;
`endif

    always_comb begin
        state_n = state;
        pc_n    = pc;
        req_n   = out_mem_req;
        addr_n  = out_mem_addr;
        valid_n = 1'b0;
        instr_n = out_decode_instr;
        dpc_n   = out_decode_pc;
        jce_n   = out_decode_jump_ce;
        case (state)
            ST_IDLE: begin
                if (in_rob_flush) begin
                    pc_n = in_rob_target_pc;
                end else if (hit) begin
                    if (!in_queue_full) begin
                        valid_n = 1'b1;
                        instr_n = rdata;
                        dpc_n   = pc;
                        jce_n   = pred_taken;
                        pc_n    = next_pc;
                    end
                end else begin
                    req_n   = 1'b1;
                    addr_n  = {pc[31:2], 2'b00};
                    state_n = ST_MISS;
                end
            end
            ST_MISS: begin
                // A flush never cancels the fill: the returned word is still correct for its address.
                if (in_mem_valid) begin
                    req_n   = 1'b0;
                    state_n = ST_IDLE;
                end
                if (in_rob_flush) pc_n = in_rob_target_pc;
            end
            default: state_n = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state              <= ST_IDLE;
            pc                 <= ZERO_DATA;
            out_mem_req        <= 1'b0;
            out_mem_addr       <= ZERO_DATA;
            out_decode_valid   <= 1'b0;
            out_decode_instr   <= ZERO_DATA;
            out_decode_pc      <= ZERO_DATA;
            out_decode_jump_ce <= 1'b0;
        end else if (rdy) begin
            state              <= state_n;
            pc                 <= pc_n;
            out_mem_req        <= req_n;
            out_mem_addr       <= addr_n;
            out_decode_valid   <= valid_n;
            out_decode_instr   <= instr_n;
            out_decode_pc      <= dpc_n;
            out_decode_jump_ce <= jce_n;
        end
    end

endmodule
